jtag_scan_ctrl: RTL
===================

Name: jtag_scan_ctrl

Overview:
Hardware JTAG scan sequencer for the simulation debug path. Accepts IR/DR scan and TAP-reset commands over a valid/ready interface and generates the TCK/TMS/TDI waveform. Samples TDO and returns the captured bits over a response valid/ready interface. Sits between an on-chip/testbench requester and the DUT debug TAP, replacing the host-driven tick loop with a self-sequencing engine.

Parameters:
TICK_DELAY, 50, clock cycles per TCK half-period minus 1; half-period = TICK_DELAY+1 cycles
MAX_LEN, 64, maximum scan length in bits
LEN_W, 7, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN

Ports:
clock  in  1  sole clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  when 0, freeze the half-period counter and hold all JTAG outputs
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved
cmd_len  in  LEN_W  scan length in bits
cmd_data  in  MAX_LEN  TDI bits, shifted LSB first
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  MAX_LEN  captured TDO bits, bit i = i-th shifted bit; bits >= len are 0
rsp_err  out  1  command rejected
busy  out  1  sequence in progress
jtag_TCK  out  1  test clock
jtag_TMS  out  1  test mode select
jtag_TDI  out  1  test data in
jtag_TRSTn  out  1  TAP reset, active low
jtag_TDO_data  in  1  TDO from the DUT
jtag_TDO_driven  in  1  TDO valid; when 0 the sampled value is 0

Behaviour:
- Reset values, all registered: jtag_TCK=0, TMS=1, TDI=0, TRSTn per the optional feature, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0.
- States: AUTO_RST, IDLE, PRE, SHIFT, POST, RESP.
- After reset_n deasserts, the FSM enters AUTO_RST with busy=1. It runs the TAP-reset sequence, then goes to IDLE. There is no response for the automatic reset.
- Bit slot timing:
  - Each slot is one TCK period: a low phase of TICK_DELAY+1 cycles, then a high phase of TICK_DELAY+1 cycles.
  - TMS/TDI update on the cycle TCK goes low.
  - TDO is sampled on the same clock edge that drives TCK 0->1.
- enable=0 stalls the counter and freezes all state mid-slot. Resuming continues without bit loss.
- cmd_ready = (state==IDLE) && !rsp_valid. On accept, the command fields are latched and busy=1.
- TAP reset (op 2): 5 slots with TMS=1, then 1 slot with TMS=0, giving 6 slots and ending in Run-Test/Idle. The response is rsp_data=0, rsp_err=0.
- DR scan (op 0), starting from Run-Test/Idle:
  - PRE: TMS 1,0,0.
  - SHIFT: len slots, TDI=data[i]; TMS=0 except the last slot, where TMS=1.
  - POST: TMS 1,0.
  - Total len+5 slots.
- IR scan (op 1): PRE is TMS 1,1,0,0, otherwise identical to DR. Total len+6 slots.
- TDO capture occurs only in SHIFT slots; the captured bit goes to rsp_data[i].
- Error commands (op 3, len==0, or len>MAX_LEN):
  - No TCK activity.
  - rsp_valid asserts on the cycle after accept, with rsp_err=1 and rsp_data=0.
- RESP state:
  - rsp_valid is held, with rsp_data/rsp_err stable, until rsp_ready.
  - Then the FSM returns to IDLE and busy=0. cmd_ready rises on the following cycle.
- Between commands, TCK idles low and TMS holds 0 (the TAP stays in Run-Test/Idle).
- reset_n low mid-scan: immediate return to reset values. Any pending response is discarded. AUTO_RST reruns on release.

Optional Feature:
- JTAG_SCAN_CTRL_TRST_EN defined:
  - jtag_TRSTn=0 while reset_n is low.
  - jtag_TRSTn=0 during the first slot of every TAP-reset sequence (automatic and op 2).
  - 1 otherwise.
- Not defined: jtag_TRSTn is constant 1 and the TAP is reset by TMS only.

Test Plan:
- Reset release, TICK_DELAY=1 -> busy=1 for 24 cycles with TMS=1 for 5 TCK rising edges and 0 on the 6th. Then cmd_ready=1 and busy=0.
- DR scan, len=8, data=0xA5, TDO_driven=1 returning 0x3C LSB first -> 13 TCK pulses (52 cycles). The TDI shift-slot sequence is 1,0,1,0,0,1,0,1. rsp_data=0x3C, rsp_err=0.
- IR scan, len=5, data=0x11, TDO_driven=0 -> 11 TCK pulses, TMS pre-sequence 1,1,0,0, rsp_data=0.
- cmd_len=0, then cmd_op=3 -> each gives rsp_valid the next cycle with rsp_err=1 and no TCK edge.
- rsp_ready held 0 for 20 cycles after completion -> rsp_valid and rsp_data stable, cmd_ready=0. Then 1-cycle rsp_ready -> cmd_ready=1 on the following cycle.
- enable=0 for 10 cycles mid-SHIFT, then reset_n pulsed low mid-scan -> no TCK change while enable=0 and the final rsp_data is correct. The reset pulse restores reset values and reruns AUTO_RST. With JTAG_SCAN_CTRL_TRST_EN, TRSTn=0 during reset.

Source files
------------

// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: self-sequencing JTAG engine that runs TAP-reset, IR-scan and DR-scan commands.
// Optional macro JTAG_SCAN_CTRL_TRST_EN drives jtag_TRSTn low during reset and in the first TAP-reset slot.
module jtag_scan_ctrl #(
  parameter int TICK_DELAY = 50,
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  output logic               jtag_TRSTn,
  input  logic               jtag_TDO_data,
  input  logic               jtag_TDO_driven
);

`ifdef JTAG_SCAN_CTRL_TRST_EN
  localparam bit TRST_EN = 1'b1;
`else
  localparam bit TRST_EN = 1'b0;
`endif

  localparam int CNT_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DELAY);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(5);
  localparam logic [1:0] OP_IR  = 2'd1;
  localparam logic [1:0] OP_RST = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [2:0] {
    AUTO_RST,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RESP
  } state_t;

  state_t             state, state_nx;
  logic               boot, boot_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [LEN_W-1:0]   slot, slot_nx;
  logic [LEN_W-1:0]   len, len_nx;
  logic               ir, ir_nx;
  logic               op_rst, op_rst_nx;
  logic [MAX_LEN-1:0] shreg, shreg_nx;
  logic [MAX_LEN-1:0] mask, mask_nx;
  logic [MAX_LEN-1:0] cap, cap_nx;
  logic               trst, trst_nx;
  logic               tck_nx, tms_nx, tdi_nx;
  logic               cmd_ready_nx, rsp_valid_nx, rsp_err_nx, busy_nx;
  logic [MAX_LEN-1:0] rsp_data_nx;
  logic               tdo_bit;
  logic               tick;
  logic               seq_state;

  assign tdo_bit    = jtag_TDO_data & jtag_TDO_driven;
  assign tick       = enable && (cnt == CNT_MAX);
  assign seq_state  = (state == AUTO_RST) || (state == PRE) || (state == SHIFT) || (state == POST);
  assign jtag_TRSTn = trst;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= AUTO_RST;
      boot      <= 1'b1;
      cnt       <= '0;
      slot      <= '0;
      len       <= '0;
      ir        <= 1'b0;
      op_rst    <= 1'b0;
      shreg     <= '0;
      mask      <= '0;
      cap       <= '0;
      trst      <= !TRST_EN;
      jtag_TCK  <= 1'b0;
      jtag_TMS  <= 1'b1;
      jtag_TDI  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      boot      <= boot_nx;
      cnt       <= cnt_nx;
      slot      <= slot_nx;
      len       <= len_nx;
      ir        <= ir_nx;
      op_rst    <= op_rst_nx;
      shreg     <= shreg_nx;
      mask      <= mask_nx;
      cap       <= cap_nx;
      trst      <= trst_nx;
      jtag_TCK  <= tck_nx;
      jtag_TMS  <= tms_nx;
      jtag_TDI  <= tdi_nx;
      cmd_ready <= cmd_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_data  <= rsp_data_nx;
      busy      <= busy_nx;
    end
  end

  // Slot boundaries fall on the TCK high->low tick; the next slot's TMS/TDI are loaded on that same edge.
  always_comb begin
    state_nx    = state;
    boot_nx     = boot;
    cnt_nx      = cnt;
    slot_nx     = slot;
    len_nx      = len;
    ir_nx       = ir;
    op_rst_nx   = op_rst;
    shreg_nx    = shreg;
    mask_nx     = mask;
    cap_nx      = cap;
    trst_nx     = trst;
    tck_nx      = jtag_TCK;
    tms_nx      = jtag_TMS;
    tdi_nx      = jtag_TDI;
    rsp_valid_nx = rsp_valid;
    rsp_err_nx  = rsp_err;
    rsp_data_nx = rsp_data;
    busy_nx     = busy;

    if (boot) begin
      boot_nx   = 1'b0;
      state_nx  = AUTO_RST;
      busy_nx   = 1'b1;
      cnt_nx    = '0;
      slot_nx   = '0;
      op_rst_nx = 1'b0;
      tck_nx    = 1'b0;
      tms_nx    = 1'b1;
      tdi_nx    = 1'b0;
      trst_nx   = !TRST_EN;
    end else if (state == IDLE) begin
      if (cmd_valid && cmd_ready) begin
        busy_nx  = 1'b1;
        len_nx   = cmd_len;
        ir_nx    = (cmd_op == OP_IR);
        shreg_nx = cmd_data;
        mask_nx  = MAX_LEN'(1);
        cap_nx   = '0;
        cnt_nx   = '0;
        slot_nx  = '0;
        tck_nx   = 1'b0;
        if (cmd_op == OP_RSV || cmd_len == '0 || cmd_len > LEN_MAX) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_data_nx  = '0;
        end else if (cmd_op == OP_RST) begin
          state_nx  = AUTO_RST;
          op_rst_nx = 1'b1;
          tms_nx    = 1'b1;
          trst_nx   = !TRST_EN;
        end else begin
          state_nx = PRE;
          tms_nx   = 1'b1;
        end
      end
    end else if (state == RESP) begin
      if (rsp_ready) begin
        state_nx     = IDLE;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_data_nx  = '0;
        busy_nx      = 1'b0;
      end
    end else if (seq_state && enable) begin
      if (!tick) begin
        cnt_nx = cnt + CNT_W'(1);
      end else begin
        cnt_nx = '0;
        tck_nx = !jtag_TCK;
        if (!jtag_TCK) begin
          if (state == SHIFT) cap_nx = cap | (mask & {MAX_LEN{tdo_bit}});
        end else begin
          case (state)
            AUTO_RST: begin
              trst_nx = 1'b1;
              if (slot == RST_LAST) begin
                if (op_rst) begin
                  state_nx     = RESP;
                  op_rst_nx    = 1'b0;
                  rsp_valid_nx = 1'b1;
                  rsp_err_nx   = 1'b0;
                  rsp_data_nx  = '0;
                end else begin
                  state_nx = IDLE;
                  busy_nx  = 1'b0;
                end
                tms_nx = 1'b0;
              end else begin
                slot_nx = slot + ONE;
                tms_nx  = (slot + ONE) != RST_LAST;
              end
            end
            PRE: begin
              if (slot == (ir ? LEN_W'(3) : LEN_W'(2))) begin
                state_nx = SHIFT;
                slot_nx  = '0;
                tms_nx   = (len == ONE);
                tdi_nx   = shreg[0];
                shreg_nx = shreg >> 1;
              end else begin
                slot_nx = slot + ONE;
                tms_nx  = ir && (slot == '0);
              end
            end
            SHIFT: begin
              mask_nx = mask << 1;
              if (slot == len - ONE) begin
                state_nx = POST;
                slot_nx  = '0;
                tms_nx   = 1'b1;
                tdi_nx   = 1'b0;
              end else begin
                slot_nx  = slot + ONE;
                tms_nx   = (slot + ONE) == (len - ONE);
                tdi_nx   = shreg[0];
                shreg_nx = shreg >> 1;
              end
            end
            POST: begin
              tms_nx = 1'b0;
              if (slot == ONE) begin
                state_nx     = RESP;
                rsp_valid_nx = 1'b1;
                rsp_err_nx   = 1'b0;
                rsp_data_nx  = cap;
              end else begin
                slot_nx = ONE;
              end
            end
            default: state_nx = IDLE;
          endcase
        end
      end
    end

    cmd_ready_nx = (state_nx == IDLE) && !rsp_valid_nx;
  end

endmodule
